// File: rtl/vram_sys_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_sys_arb_pkg
//  Purpose  : Shared system constants and types for the VRAM system-port
//             arbiter: word/address widths, requester ids, read-tag record.
//  Revision : 1.0  initial release
// ============================================================================
package vram_sys_arb_pkg;

  // Machine word / vram data width and vram word-address width
  localparam int WORD       = 32;
  localparam int VRAM_ADDRW = 14;

  // Requester identifiers
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_GFX = 1'b1
  } port_e;

  // In-flight read tag: one entry per pipeline stage
  typedef struct packed {
    logic  valid;
    port_e port;
  } rd_tag_t;

  // One-hot grant vector for a requester id
  function automatic logic [1:0] port_onehot(input port_e p);
    return (p == PORT_GFX) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : arb_rr2
//  Purpose  : Two-way round-robin grant with lock override. A locked port
//             that is still valid keeps the grant; otherwise the port not
//             granted most recently wins contention, and a sole requester
//             always wins.
//  Revision : 1.0  initial release
// ============================================================================
module arb_rr2
  import vram_sys_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lock,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant selection: lock first, then round-robin, then sole requester
  always_comb begin
    grant = 2'b00;
    if (lock && valid[last]) begin
      grant = port_onehot(port_e'(last));
    end else if (valid == 2'b11) begin
      grant = port_onehot(port_e'(~last));
    end else begin
      grant = valid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_sys_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vram_sys_arb
//  Purpose  : Arbitrates the cpu (port 0) and gfx (port 1) requesters onto
//             the single vram system port. One beat per cycle is registered
//             onto the vram side; reads are tracked by a tag pipeline so the
//             response lands on the issuing port 1+VRAM_LAT cycles later.
//  Revision : 1.0  initial release
// ============================================================================
module vram_sys_arb #(
  parameter int WORD     = vram_sys_arb_pkg::WORD,
  parameter int ADDRW    = vram_sys_arb_pkg::VRAM_ADDRW,
  parameter int VRAM_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  // requester 0 (cpu)
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WORD-1:0]  req0_wmask,
  input  logic [ADDRW-1:0] req0_addr,
  input  logic [WORD-1:0]  req0_din,
  input  logic             req0_lock,
  output logic             rsp0_valid,
  output logic [WORD-1:0]  rsp0_data,
  // requester 1 (gfx)
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WORD-1:0]  req1_wmask,
  input  logic [ADDRW-1:0] req1_addr,
  input  logic [WORD-1:0]  req1_din,
  input  logic             req1_lock,
  output logic             rsp1_valid,
  output logic [WORD-1:0]  rsp1_data,
  // vram system port
  output logic [WORD-1:0]  vram_wmask,
  output logic [ADDRW-1:0] vram_addr,
  output logic [WORD-1:0]  vram_din,
  input  logic [WORD-1:0]  vram_dout
);

  import vram_sys_arb_pkg::*;

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic             w_hs;
  logic             w_sel;
  logic [WORD-1:0]  w_wmask;
  logic [ADDRW-1:0] w_addr;
  logic [WORD-1:0]  w_din;
  logic             w_lock;
  rd_tag_t          w_new_tag;
  rd_tag_t          w_rsp_tag;

  logic             r_last;
  logic             r_lock;
  logic [WORD-1:0]  r_vram_wmask;
  logic [ADDRW-1:0] r_vram_addr;
  logic [WORD-1:0]  r_vram_din;
  rd_tag_t [VRAM_LAT:0] r_tag;

  assign w_valid = {req1_valid, req0_valid};

  arb_rr2 u_arb (
    .valid (w_valid),
    .lock  (r_lock),
    .last  (r_last),
    .grant (w_grant)
  );

  // Ready is the grant itself, suppressed while reset is asserted
  assign req0_ready = w_grant[0] & rst_sys_n;
  assign req1_ready = w_grant[1] & rst_sys_n;
  assign w_hs       = req0_ready | req1_ready;
  assign w_sel      = w_grant[1];

  // Beat selection from the granted port
  always_comb begin
    w_wmask = req0_wmask;
    w_addr  = req0_addr;
    w_din   = req0_din;
    w_lock  = req0_lock;
    if (w_sel) begin
      w_wmask = req1_wmask;
      w_addr  = req1_addr;
      w_din   = req1_din;
      w_lock  = req1_lock;
    end
  end

  // Round-robin pointer and lock: a lock lasts exactly one beat and lapses
  // in any cycle without a handshake
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_last <= 1'b1;
      r_lock <= 1'b0;
    end else if (w_hs) begin
      r_last <= w_sel;
      r_lock <= w_lock;
    end else begin
      r_lock <= 1'b0;
    end
  end

  // Registered vram beat; idle cycles issue a harmless read (mask 0)
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_vram_wmask <= '0;
      r_vram_addr  <= '0;
      r_vram_din   <= '0;
    end else if (w_hs) begin
      r_vram_wmask <= w_wmask;
      r_vram_addr  <= w_addr;
      r_vram_din   <= w_din;
    end else begin
      r_vram_wmask <= '0;
    end
  end

  assign vram_wmask = r_vram_wmask;
  assign vram_addr  = r_vram_addr;
  assign vram_din   = r_vram_din;

  // Only accepted reads enter the tag pipeline; writes never respond
  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_hs && (w_wmask == '0);
    w_new_tag.port  = port_e'(w_sel);
  end

  // Tag shift register: stage k holds reads issued k+1 cycles ago
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_new_tag;
      for (int i = 1; i <= VRAM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Response steering: vram_dout is valid while the oldest tag is at the end
  assign w_rsp_tag  = r_tag[VRAM_LAT];
  assign rsp0_valid = rst_sys_n & w_rsp_tag.valid & (w_rsp_tag.port == PORT_CPU);
  assign rsp1_valid = rst_sys_n & w_rsp_tag.valid & (w_rsp_tag.port == PORT_GFX);
  assign rsp0_data  = rsp0_valid ? vram_dout : '0;
  assign rsp1_data  = rsp1_valid ? vram_dout : '0;

endmodule
`default_nettype wire
